// File: rtl/alarm_pkg.sv
// Shared definitions for the door alarm controller: FSM state encoding,
// default delay constants and the countdown timer width.
package alarm_pkg;

  localparam int TIMER_W           = 4;
  localparam int EXIT_DELAY_DEF    = 4;
  localparam int ENTRY_DELAY_DEF   = 3;
  localparam int SIREN_TIME_DEF    = 8;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter used for the exit, entry and siren countdowns.
// Ports:
//   clk_2    - clock, rising edge
//   rst_n    - asynchronous active-low reset, clears the count to 0
//   load     - load load_val (has priority over dec)
//   load_val - value to load
//   dec      - decrement by one; holds at 0, never wraps
//   value    - current count
//   zero     - 1 when value is 0
module alarm_timer
  import alarm_pkg::*;
(
  input  logic               clk_2,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic [TIMER_W-1:0] value,
  output logic               zero
);

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/alarm_controller.sv
// Door alarm controller: arms on a manual switch or at night, gives an exit
// delay before arming, an entry delay before the siren, and repeats siren
// bursts while the door stays open. Counts alarm activations.
// Ports:
//   clk_2       - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   porta       - door sensor, 1 = open
//   relogio     - time of day, 1 = day, 0 = night
//   interruptor - manual arm switch, 1 = arm request
//   siren       - 1 while sounding (ALARM only)
//   armed       - 1 in ARMED, ENTRY or ALARM
//   state_o     - current state encoding
//   timer_o     - current countdown value (0 in DISARMED/ARMED)
//   event_cnt   - alarm activations since reset, saturating at 255
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int EXIT_DELAY  = EXIT_DELAY_DEF,
  parameter int ENTRY_DELAY = ENTRY_DELAY_DEF,
  parameter int SIREN_TIME  = SIREN_TIME_DEF
) (
  input  logic               clk_2,
  input  logic               rst_n,
  input  logic               porta,
  input  logic               relogio,
  input  logic               interruptor,
  output logic               siren,
  output logic               armed,
  output logic [2:0]         state_o,
  output logic [TIMER_W-1:0] timer_o,
  output logic [7:0]         event_cnt
);

  localparam logic [TIMER_W-1:0] EXIT_LD  = TIMER_W'(EXIT_DELAY - 1);
  localparam logic [TIMER_W-1:0] ENTRY_LD = TIMER_W'(ENTRY_DELAY - 1);
  localparam logic [TIMER_W-1:0] SIREN_LD = TIMER_W'(SIREN_TIME - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t             state_q;
  state_t             state_nx;
  logic               arm_req;
  logic               t_load;
  logic [TIMER_W-1:0] t_load_val;
  logic               t_dec;
  logic               t_zero;
  logic               cnt_inc;
  logic               siren_q;
  logic               armed_q;

  assign arm_req = interruptor | ~relogio;

  alarm_timer u_timer (
    .clk_2    (clk_2),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_load_val),
    .dec      (t_dec),
    .value    (timer_o),
    .zero     (t_zero)
  );

  // Disarm is checked first in every state so it beats an open door.
  // Leaving a counting state early reloads the timer with 0 so timer_o
  // reads 0 in DISARMED.
  always_comb begin
    state_nx   = state_q;
    t_load     = 1'b0;
    t_load_val = '0;
    t_dec      = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      ST_DISARMED: begin
        if (arm_req) begin
          state_nx   = ST_EXIT;
          t_load     = 1'b1;
          t_load_val = EXIT_LD;
        end
      end
      ST_EXIT: begin
        if (!arm_req) begin
          state_nx = ST_DISARMED;
          t_load   = 1'b1;
        end else if (t_zero) begin
          state_nx = ST_ARMED;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_ARMED: begin
        if (!arm_req) begin
          state_nx = ST_DISARMED;
        end else if (porta) begin
          state_nx   = ST_ENTRY;
          t_load     = 1'b1;
          t_load_val = ENTRY_LD;
        end
      end
      ST_ENTRY: begin
        if (!arm_req) begin
          state_nx = ST_DISARMED;
          t_load   = 1'b1;
        end else if (t_zero) begin
          state_nx   = ST_ALARM;
          t_load     = 1'b1;
          t_load_val = SIREN_LD;
          cnt_inc    = 1'b1;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_ALARM: begin
        if (!arm_req) begin
          state_nx = ST_DISARMED;
          t_load   = 1'b1;
        end else if (t_zero && !porta) begin
          state_nx = ST_ARMED;
        end else if (t_zero) begin
          // Door still open: another burst, same activation.
          t_load     = 1'b1;
          t_load_val = SIREN_LD;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: begin
        state_nx = ST_DISARMED;
        t_load   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_DISARMED;
      siren_q   <= 1'b0;
      armed_q   <= 1'b0;
      event_cnt <= 8'd0;
    end else begin
      state_q <= state_nx;
      siren_q <= (state_nx == ST_ALARM);
      armed_q <= (state_nx == ST_ARMED) || (state_nx == ST_ENTRY) ||
                 (state_nx == ST_ALARM);
      if (cnt_inc) begin
        event_cnt <= sat_inc(event_cnt);
      end
    end
  end

  assign state_o = state_q;
  assign siren   = siren_q;
  assign armed   = armed_q;

endmodule

// File: tb/tb_alarm_controller.sv
module tb_alarm_controller;

  localparam int EXIT_D  = 4;
  localparam int ENTRY_D = 3;
  localparam int SIREN_D = 8;

  localparam int M_DIS   = 0;
  localparam int M_EXIT  = 1;
  localparam int M_ARMED = 2;
  localparam int M_ENTRY = 3;
  localparam int M_ALARM = 4;

  logic       clk_2 = 1'b0;
  logic       rst_n;
  logic       porta;
  logic       relogio;
  logic       interruptor;
  logic       siren;
  logic       armed;
  logic [2:0] state_o;
  logic [3:0] timer_o;
  logic [7:0] event_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode, cycles left in the current countdown, activations.
  int m_mode;
  int m_left;
  int m_events;

  alarm_controller #(
    .EXIT_DELAY  (EXIT_D),
    .ENTRY_DELAY (ENTRY_D),
    .SIREN_TIME  (SIREN_D)
  ) dut (
    .clk_2       (clk_2),
    .rst_n       (rst_n),
    .porta       (porta),
    .relogio     (relogio),
    .interruptor (interruptor),
    .siren       (siren),
    .armed       (armed),
    .state_o     (state_o),
    .timer_o     (timer_o),
    .event_cnt   (event_cnt)
  );

  always #5 clk_2 = ~clk_2;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_DIS;
    m_left   = 0;
    m_events = 0;
  endtask

  // One clock of the behavioural rules, given the inputs seen at the edge.
  task automatic model_clock(input bit door, input bit day, input bit sw);
    bit want_armed;
    want_armed = sw || !day;
    if (!want_armed) begin
      m_mode = M_DIS;
      m_left = 0;
    end else begin
      unique case (m_mode)
        M_DIS: begin
          m_mode = M_EXIT;
          m_left = EXIT_D - 1;
        end
        M_EXIT: begin
          if (m_left > 0) m_left = m_left - 1;
          else m_mode = M_ARMED;
        end
        M_ARMED: begin
          if (door) begin
            m_mode = M_ENTRY;
            m_left = ENTRY_D - 1;
          end
        end
        M_ENTRY: begin
          if (m_left > 0) m_left = m_left - 1;
          else begin
            m_mode   = M_ALARM;
            m_left   = SIREN_D - 1;
            m_events = (m_events < 255) ? m_events + 1 : 255;
          end
        end
        default: begin
          if (m_left > 0) m_left = m_left - 1;
          else if (door) m_left = SIREN_D - 1;
          else m_mode = M_ARMED;
        end
      endcase
    end
  endtask

  task automatic check_all();
    check("state_o", int'(state_o), m_mode);
    check("timer_o", int'(timer_o), m_left);
    check("siren", int'(siren), (m_mode == M_ALARM) ? 1 : 0);
    check("armed", int'(armed), (m_mode >= M_ARMED) ? 1 : 0);
    check("event_cnt", int'(event_cnt), m_events);
  endtask

  // Called at a falling edge: drive, clock once, compare at next falling edge.
  task automatic step(input bit door, input bit day, input bit sw);
    porta       = door;
    relogio     = day;
    interruptor = sw;
    @(posedge clk_2);
    model_clock(door, day, sw);
    @(negedge clk_2);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_2);
    model_reset();
    rst_n = 1'b1;
  endtask

  int ev_hold;

  initial begin
    rst_n       = 1'b0;
    porta       = 1'b1;
    relogio     = 1'b0;
    interruptor = 1'b1;
    model_reset();
    #2;
    check("rst_state", int'(state_o), 0);
    check("rst_siren", int'(siren), 0);
    repeat (3) @(negedge clk_2);
    check("rst_armed", int'(armed), 0);
    check("rst_timer", int'(timer_o), 0);
    check("rst_events", int'(event_cnt), 0);
    check("rst_state_clk", int'(state_o), 0);
    porta = 1'b0;
    rst_n = 1'b1;

    // Exit delay
    step(0, 0, 0);
    check("exit_state", int'(state_o), 1);
    check("exit_t3", int'(timer_o), 3);
    step(0, 0, 0); check("exit_t2", int'(timer_o), 2);
    step(0, 0, 0); check("exit_t1", int'(timer_o), 1);
    step(0, 0, 0); check("exit_t0", int'(timer_o), 0);
    step(0, 0, 0);
    check("armed_state", int'(state_o), 2);
    check("armed_flag", int'(armed), 1);

    // Entry and alarm
    step(1, 0, 0);
    check("entry_state", int'(state_o), 3);
    step(0, 0, 0);
    step(0, 0, 0);
    check("entry_still", int'(state_o), 3);
    step(0, 0, 0);
    check("alarm_siren", int'(siren), 1);
    check("alarm_events", int'(event_cnt), 1);
    for (int i = 0; i < SIREN_D - 1; i++) begin
      step(0, 0, 0);
      check("siren_hold", int'(siren), 1);
    end
    step(0, 0, 0);
    check("alarm_end_state", int'(state_o), 2);
    check("alarm_end_siren", int'(siren), 0);

    // Retrigger with door held open
    step(1, 0, 0);
    for (int i = 0; i < ENTRY_D; i++) step(1, 0, 0);
    ev_hold = int'(event_cnt);
    check("retrig_events", ev_hold, 2);
    for (int i = 0; i < 2 * SIREN_D + 2; i++) begin
      step(1, 0, 0);
      check("retrig_siren", int'(siren), 1);
    end
    check("retrig_cnt_same", int'(event_cnt), ev_hold);
    for (int i = 0; i < SIREN_D + 2; i++) step(0, 0, 0);
    check("retrig_back_armed", int'(state_o), 2);

    // Disarm beats open door in ENTRY
    step(1, 0, 0);
    check("prio_in_entry", int'(state_o), 3);
    step(1, 1, 0);
    check("prio_state", int'(state_o), 0);
    check("prio_armed", int'(armed), 0);
    check("prio_siren", int'(siren), 0);

    // Asynchronous reset in the middle of an alarm
    for (int i = 0; i < EXIT_D + 1; i++) step(0, 0, 1);
    step(1, 0, 1);
    for (int i = 0; i < ENTRY_D; i++) step(0, 0, 1);
    check("pre_rst_siren", int'(siren), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_siren", int'(siren), 0);
    check("async_events", int'(event_cnt), 0);
    check("async_state", int'(state_o), 0);
    @(negedge clk_2);
    model_reset();
    rst_n = 1'b1;

    // Saturation: open the door whenever armed, close it otherwise
    for (int i = 0; i < EXIT_D + 1; i++) step(0, 0, 0);
    for (int n = 0; n < 260 * 12 + 20; n++) begin
      step((m_mode == M_ARMED) ? 1'b1 : 1'b0, 0, 0);
    end
    check("sat_events", int'(event_cnt), 255);
    check("sat_model", m_events, int'(event_cnt));

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
